// File: rtl/jk_bank_if.sv
// Bundle of per-channel controls and outputs for jk_bank.
// Defining JK_BANK_PRESET_EN adds the per-channel preset signal PRE_CH.
interface jk_bank_if #(
    parameter int unsigned WIDTH = 2
);
    logic [WIDTH-1:0] CLR_CH;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic [1:0]       MODE;
    logic             CE;
    logic             LD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_bar;
    logic             TC;
`ifdef JK_BANK_PRESET_EN
    logic [WIDTH-1:0] PRE_CH;
`endif

    modport master (
`ifdef JK_BANK_PRESET_EN
        output PRE_CH,
`endif
        output CLR_CH, J, K, MODE, CE, LD, D,
        input  Q, Q_bar, TC
    );

    modport slave (
`ifdef JK_BANK_PRESET_EN
        input  PRE_CH,
`endif
        input  CLR_CH, J, K, MODE, CE, LD, D,
        output Q, Q_bar, TC
    );
endinterface

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops that can also run as an up/down counter with parallel load.
// Defining JK_BANK_PRESET_EN enables the per-channel preset PRE_CH.
module jk_bank #(
    parameter int unsigned      WIDTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic       CLK,
    input  logic       CLR,
    jk_bank_if.slave   bus
);
    localparam logic [1:0] ModeJk   = 2'b00;
    localparam logic [1:0] ModeUp   = 2'b01;
    localparam logic [1:0] ModeDown = 2'b10;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (bus.LD) begin
            q_d = bus.D;
        end else if (bus.CE) begin
            case (bus.MODE)
                ModeJk:   q_d = (bus.J & ~q_q) | (~bus.K & q_q);
                ModeUp:   q_d = q_q + WIDTH'(1);
                ModeDown: q_d = q_q - WIDTH'(1);
                default:  q_d = q_q;
            endcase
        end
`ifdef JK_BANK_PRESET_EN
        q_d = q_d | bus.PRE_CH;
`endif
        // Clear is applied last so it wins over preset, load and counting.
        q_d = q_d & ~bus.CLR_CH;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.Q     = q_q;
    assign bus.Q_bar = ~q_q;
    assign bus.TC    = bus.CE & (((bus.MODE == ModeUp) & (&q_q)) |
                                 ((bus.MODE == ModeDown) & ~(|q_q)));
endmodule

// File: tb/tb_jk_bank.sv
// Scoreboard bench for jk_bank: two instances (RESET_VALUE 1010 and 0000) share stimulus.
// Build with JK_BANK_PRESET_EN defined to also exercise PRE_CH.
module tb_jk_bank;
    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] qa;
        logic [W-1:0] qb;
        logic         tca;
        logic         tcb;
        int           id;
    } exp_t;

    logic         clk = 1'b0;
    logic         clr;
    logic [W-1:0] clr_ch, j, k, d, pre;
    logic [1:0]   mode;
    logic         ce, ld;

    logic [W-1:0] qa_m, qb_m;
    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           step_id  = 0;

    jk_bank_if #(.WIDTH(W)) if_a ();
    jk_bank_if #(.WIDTH(W)) if_b ();

    assign if_a.CLR_CH = clr_ch;  assign if_b.CLR_CH = clr_ch;
    assign if_a.J      = j;       assign if_b.J      = j;
    assign if_a.K      = k;       assign if_b.K      = k;
    assign if_a.MODE   = mode;    assign if_b.MODE   = mode;
    assign if_a.CE     = ce;      assign if_b.CE     = ce;
    assign if_a.LD     = ld;      assign if_b.LD     = ld;
    assign if_a.D      = d;       assign if_b.D      = d;
`ifdef JK_BANK_PRESET_EN
    assign if_a.PRE_CH = pre;     assign if_b.PRE_CH = pre;
`endif

    jk_bank #(.WIDTH(W), .RESET_VALUE(4'b1010)) dut_a (.CLK(clk), .CLR(clr), .bus(if_a));
    jk_bank #(.WIDTH(W), .RESET_VALUE(4'b0000)) dut_b (.CLK(clk), .CLR(clr), .bus(if_b));

    always #5 clk = ~clk;

    // Reference: per-channel priority clear > preset > load > mode action, counting as integers.
    function automatic logic [W-1:0] model(input logic [W-1:0] q, input logic [W-1:0] rv);
        logic [W-1:0] nq;
        int unsigned  up, dn;
        if (clr) return rv;
        up = (int'(q) + 1) % 16;
        dn = (int'(q) + 15) % 16;
        for (int i = 0; i < W; i++) begin
            if (clr_ch[i])      nq[i] = 1'b0;
            else if (pre[i])    nq[i] = 1'b1;
            else if (ld)        nq[i] = d[i];
            else if (!ce)       nq[i] = q[i];
            else if (mode == 2'd0) begin
                if (j[i] && k[i])  nq[i] = !q[i];
                else if (j[i])     nq[i] = 1'b1;
                else if (k[i])     nq[i] = 1'b0;
                else               nq[i] = q[i];
            end
            else if (mode == 2'd1) nq[i] = up[i];
            else if (mode == 2'd2) nq[i] = dn[i];
            else                   nq[i] = q[i];
        end
        return nq;
    endfunction

    function automatic logic tc_model(input logic [W-1:0] q);
        return ce && ((mode == 2'd1 && q == 4'd15) || (mode == 2'd2 && q == 4'd0));
    endfunction

    task automatic step(input logic c, input logic [W-1:0] cc, input logic [W-1:0] jj,
                        input logic [W-1:0] kk, input logic [1:0] m, input logic e,
                        input logic l, input logic [W-1:0] dd, input logic [W-1:0] pp);
        exp_t x;
        @(negedge clk);
        clr = c; clr_ch = cc; j = jj; k = kk; mode = m; ce = e; ld = l; d = dd;
`ifdef JK_BANK_PRESET_EN
        pre = pp;
`else
        pre = 4'b0000 & pp;
`endif
        qa_m = model(qa_m, 4'b1010);
        qb_m = model(qb_m, 4'b0000);
        x.qa = qa_m; x.qb = qb_m;
        x.tca = tc_model(qa_m); x.tcb = tc_model(qb_m);
        x.id = step_id++;
        sb.push_back(x);
    endtask

    task automatic chk(input string name, input int id, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %b, required %b", name, id, act, req);
        end
    endtask

    // Monitor: every edge presents a new Q; pop the matching expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("Q_a",     x.id, if_a.Q,     x.qa);
                chk("Qbar_a",  x.id, if_a.Q_bar, ~x.qa);
                chk("TC_a",    x.id, {3'b000, if_a.TC}, {3'b000, x.tca});
                chk("Q_b",     x.id, if_b.Q,     x.qb);
                chk("Qbar_b",  x.id, if_b.Q_bar, ~x.qb);
                chk("TC_b",    x.id, {3'b000, if_b.TC}, {3'b000, x.tcb});
            end
        end
    end

    initial begin
        int guard;
        qa_m = 'x; qb_m = 'x; pre = '0;
        //    clr  clr_ch j        k        mode   ce    ld    d        pre
        step(1'b1, 4'h0, 4'h0,    4'h0,    2'd3, 1'b0, 1'b0, 4'h0,    4'h0);
        repeat (3) step(1'b0, 4'h0, 4'h0, 4'h0, 2'd3, 1'b0, 1'b0, 4'h0, 4'h0);
        step(1'b0, 4'h0, 4'h0,    4'h0,    2'd3, 1'b0, 1'b1, 4'b0000, 4'h0);
        step(1'b0, 4'h0, 4'b0011, 4'b0000, 2'd0, 1'b1, 1'b0, 4'h0,    4'h0);
        step(1'b0, 4'h0, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 4'h0,    4'h0);
        step(1'b0, 4'h0, 4'b1111, 4'b1111, 2'd0, 1'b1, 1'b0, 4'h0,    4'h0);
        step(1'b0, 4'h0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 4'h0,    4'h0);
        step(1'b0, 4'h0, 4'h0,    4'h0,    2'd1, 1'b1, 1'b1, 4'b1110, 4'h0);
        step(1'b0, 4'h0, 4'h0,    4'h0,    2'd1, 1'b1, 1'b0, 4'h0,    4'h0);
        step(1'b0, 4'h0, 4'h0,    4'h0,    2'd1, 1'b1, 1'b0, 4'h0,    4'h0);
        step(1'b0, 4'h0, 4'h0,    4'h0,    2'd1, 1'b0, 1'b0, 4'h0,    4'h0);
        step(1'b0, 4'h0, 4'h0,    4'h0,    2'd2, 1'b1, 1'b1, 4'b0001, 4'h0);
        step(1'b0, 4'h0, 4'h0,    4'h0,    2'd2, 1'b1, 1'b0, 4'h0,    4'h0);
        step(1'b0, 4'h0, 4'h0,    4'h0,    2'd2, 1'b1, 1'b0, 4'h0,    4'h0);
        step(1'b0, 4'h0, 4'h0,    4'h0,    2'd3, 1'b0, 1'b1, 4'b0101, 4'h0);
        step(1'b0, 4'b0001, 4'h0, 4'h0,    2'd1, 1'b1, 1'b1, 4'b1111, 4'h0);
        step(1'b1, 4'b0001, 4'h0, 4'h0,    2'd1, 1'b1, 1'b1, 4'b1111, 4'h0);
        step(1'b0, 4'h0, 4'h0,    4'h0,    2'd3, 1'b0, 1'b0, 4'h0,    4'b1001);
        step(1'b0, 4'b0100, 4'h0, 4'h0,    2'd3, 1'b0, 1'b0, 4'h0,    4'b0110);
        for (int n = 0; n < 400; n++) begin
            step(($urandom % 25) == 0, (($urandom % 4) == 0) ? 4'($urandom) : 4'h0,
                 4'($urandom), 4'($urandom), 2'($urandom),
                 ($urandom % 5) != 0, ($urandom % 8) == 0, 4'($urandom),
                 (($urandom % 4) == 0) ? 4'($urandom) : 4'h0);
        end
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jk_bank.md
Name: jk_bank

Overview:
- Parametrised bank of WIDTH JK flip-flops on one clock.
- Each channel has its own J/K and synchronous clear.
- A mode input can instead run the whole bank as a synchronous up/down binary counter with parallel load and terminal-count output.
- Intended as a drop-in register/counter primitive for SAP datapath blocks (program counter, ring/step counters, flag registers).

Parameters:
- WIDTH, 2, number of flip-flop channels (>=1).
- RESET_VALUE, 0, WIDTH-bit value loaded into Q by global reset.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- CLR  input  1  synchronous active-high global reset.
- CLR_CH  input  WIDTH  per-channel synchronous clear, active-high.
- J  input  WIDTH  per-channel J (MODE=00 only).
- K  input  WIDTH  per-channel K (MODE=00 only).
- MODE  input  2  00 JK, 01 count up, 10 count down, 11 hold.
- CE  input  1  clock enable for MODE 00/01/10.
- LD  input  1  synchronous parallel load.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  flip-flop state.
- Q_bar  output  WIDTH  always ~Q.
- TC  output  1  terminal count, combinational.

Behaviour:
- Single clock domain (CLK); reset CLR is synchronous and active-high; no asynchronous paths.
- Reset: CLR=1 at a rising edge -> Q=RESET_VALUE, Q_bar=~RESET_VALUE. TC then follows its combinational rule.
- Per-edge priority, highest first:
  - CLR
  - CLR_CH
  - LD
  - MODE/CE action
- CLR_CH[i]=1 -> Q[i]=0 regardless of LD/mode. Channels with CLR_CH[i]=0 still take the lower-priority action that same edge.
- LD=1 (CE ignored) -> Q=D on all channels not being cleared.
- MODE=00, CE=1, per channel i:
  - J=0,K=0 hold
  - J=0,K=1 -> 0
  - J=1,K=0 -> 1
  - J=1,K=1 toggle
- MODE=01, CE=1: Q=Q+1 mod 2^WIDTH (all-ones wraps to 0).
- MODE=10, CE=1: Q=Q-1 mod 2^WIDTH (0 wraps to all-ones).
- Counting is applied before masking: channels with CLR_CH set read 0, the rest take their bit of the incremented/decremented value.
- MODE=11, or CE=0 with LD=0: hold.
- J/K ignored outside MODE=00.
- TC = CE & ((MODE==01 & Q==all-ones) | (MODE==10 & Q==0)); 0 in MODE 00/11. TC is the cascade enable for the next bank's CE (ripple-carry style, zero latency).
- Latency: all state changes 1 edge; Q_bar and TC combinational from Q/MODE/CE.
- Mode change mid-count: the new mode takes effect at the same edge it is sampled; no state is retained across modes except Q.
- Reset mid-operation: CLR overrides everything the same edge; counting resumes from RESET_VALUE the next enabled edge.
- Outputs are X-free once the first CLR edge has occurred; the bench always applies CLR first.

Optional Feature:
- Macro: JK_BANK_PRESET_EN.
- Defined:
  - Adds port PRE_CH input WIDTH, per-channel synchronous preset (Q[i]=1).
  - Priority is below CLR and CLR_CH, above LD. If CLR_CH[i] and PRE_CH[i] are both set, the clear wins.
- Undefined: port absent; behaviour otherwise identical.

Test Plan (WIDTH=4, RESET_VALUE=4'b0000 unless noted):
- CLR=1 one edge with RESET_VALUE=4'b1010 -> Q=1010, Q_bar=0101. Then CLR=0, MODE=11 for 3 edges -> Q stays 1010.
- MODE=00, CE=1, from Q=0000:
  - J=0011,K=0000 -> Q=0011
  - J=0000,K=0001 -> Q=0010
  - J=1111,K=1111 -> Q=1101
  - J=K=0000 -> Q=1101 held
- MODE=01, CE=1, LD with D=1110 -> Q=1110, TC=0. Next edge -> Q=1111, TC=1. Next -> Q=0000, TC=0. CE=0 -> TC=0 and Q holds.
- MODE=10, CE=1, from Q=0001:
  - edge -> Q=0000, TC=1
  - edge -> Q=1111, TC=0
- Priority: Q=0101, MODE=01, CE=1, LD=1, D=1111, CLR_CH=0001 -> Q=1110. Same stimulus with CLR=1 -> Q=0000.
- JK_BANK_PRESET_EN defined, MODE=11:
  - PRE_CH=1001 -> Q=1001
  - PRE_CH=0110 with CLR_CH=0100 -> Q=1011
  - Undefined build compiles without PRE_CH and passes the other five tests.
